// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Data-memory responder for the load/store path. It accepts one
//            word request at a time from the decoder controls and holds the
//            pipeline with stall while a fixed-latency access completes.
//            Loads return registered data with a one-cycle valid pulse.
// Ports    : clk         - rising-edge clock
//            rst_n       - asynchronous active-low reset
//            mem_read    - load request
//            mem_write   - store request (wins when both are high)
//            addr        - byte address from the ALU
//            wdata       - store data
//            rdata       - load data, meaningful while rdata_valid=1
//            rdata_valid - one-cycle pulse when load data is presented
//            stall       - hold the pipeline; request inputs must stay stable
//            addr_err    - one-cycle pulse when a request is rejected
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              stall,
    output logic              addr_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_store;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic w_req;
    logic w_bad;
    logic w_accept;
    logic w_last;

    assign w_req    = mem_read | mem_write;
    // Word-aligned and inside the storage; the upper address bits take part
    // in the range check so aliasing addresses are rejected, not wrapped.
    assign w_bad    = (addr[1:0] != 2'b00) |
                      ({2'b00, addr[31:2]} >= 32'(DEPTH));
    assign w_accept = (r_state == S_IDLE) & w_req & ~w_bad;
    assign w_last   = (r_state == S_WAIT) && (r_cnt == '0);

    // Stall rises in the acceptance cycle itself so the pipeline never moves
    // past a request that has just been taken. Gated by rst_n so every output
    // reads 0 while reset is asserted, even with a request still present.
    assign stall = rst_n & ((r_state == S_WAIT) | w_accept);

    // Storage is not reset. A reset during an access forces the FSM to IDLE
    // asynchronously, so w_last is low and the pending store is dropped.
    always_ff @(posedge clk) begin
        if (w_last && r_store) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_store     <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            addr_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_bad) begin
                            addr_err <= 1'b1;
                        end else begin
                            // A simultaneous read+write is treated as a store.
                            r_store <= mem_write;
                            r_idx   <= addr[2 +: IDX_W];
                            r_wdata <= wdata;
                            r_cnt   <= CNT_W'(LATENCY - 1);
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        if (!r_store) begin
                            rdata       <= r_mem[r_idx];
                            rdata_valid <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Requests are not sampled here; the pipeline advances
                    // on this edge and presents its next request in IDLE.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Directed self-checking bench for data_mem_responder
//            (LATENCY=2, DEPTH=256). Each scenario task drives its stimulus
//            and compares the captured per-cycle outputs against
//            hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        stall;
    logic        addr_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Outputs captured at the falling edge of each cycle of a scenario.
    logic        obs_stall [16];
    logic        obs_valid [16];
    logic        obs_err   [16];
    logic [31:0] obs_rdata [16];

    data_mem_responder #(
        .DATA_W  (32),
        .DEPTH   (256),
        .LATENCY (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .stall       (stall),
        .addr_err    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a request for nreq cycles, then idle inputs, for ncyc cycles in
    // total; cycle 0 is the first cycle the request is visible.
    task automatic run_access(input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] d,
                              input int nreq, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            if (c < nreq) begin
                mem_read = rd; mem_write = wr; addr = a; wdata = d;
            end else begin
                mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
            end
            @(negedge clk);
            obs_stall[c] = stall;
            obs_valid[c] = rdata_valid;
            obs_err[c]   = addr_err;
            obs_rdata[c] = rdata;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want %h", rdata, 32'h0); end
        n_cmp++;
        if (rdata_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rdata_valid); end
        n_cmp++;
        if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", addr_err); end
        n_cmp++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
        rst_n = 1'b1;
    endtask

    task automatic test_store();
        bit exp_s [5];
        exp_s = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        run_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4, 5);
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (obs_stall[c] !== exp_s[c]) begin n_fail++; $display("FAIL sw_stall cyc%0d got %b want %b", c, obs_stall[c], exp_s[c]); end
            n_cmp++;
            if (obs_valid[c] !== 1'b0) begin n_fail++; $display("FAIL sw_valid cyc%0d got %b want 0", c, obs_valid[c]); end
        end
    endtask

    task automatic test_load();
        bit exp_s [5];
        bit exp_v [5];
        exp_s = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        run_access(1'b1, 1'b0, 32'h10, 32'h0, 4, 5);
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (obs_stall[c] !== exp_s[c]) begin n_fail++; $display("FAIL lw_stall cyc%0d got %b want %b", c, obs_stall[c], exp_s[c]); end
            n_cmp++;
            if (obs_valid[c] !== exp_v[c]) begin n_fail++; $display("FAIL lw_valid cyc%0d got %b want %b", c, obs_valid[c], exp_v[c]); end
        end
        n_cmp++;
        if (obs_rdata[3] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata got %h want %h", obs_rdata[3], 32'hDEADBEEF); end
        // rdata holds after the valid pulse.
        n_cmp++;
        if (obs_rdata[4] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata_hold got %h want %h", obs_rdata[4], 32'hDEADBEEF); end
    endtask

    task automatic test_addr_err();
        bit          exp_e [3];
        logic [31:0] bad_addr [2];
        exp_e    = '{1'b0, 1'b1, 1'b0};
        bad_addr = '{32'h12, 32'h400};
        for (int k = 0; k < 2; k++) begin
            run_access(1'b1, 1'b0, bad_addr[k], 32'h0, 1, 3);
            for (int c = 0; c < 3; c++) begin
                n_cmp++;
                if (obs_err[c] !== exp_e[c]) begin n_fail++; $display("FAIL err_pulse a=%h cyc%0d got %b want %b", bad_addr[k], c, obs_err[c], exp_e[c]); end
                n_cmp++;
                if (obs_stall[c] !== 1'b0) begin n_fail++; $display("FAIL err_stall a=%h cyc%0d got %b want 0", bad_addr[k], c, obs_stall[c]); end
                n_cmp++;
                if (obs_valid[c] !== 1'b0) begin n_fail++; $display("FAIL err_valid a=%h cyc%0d got %b want 0", bad_addr[k], c, obs_valid[c]); end
            end
        end
        // Storage untouched by the rejected requests.
        run_access(1'b1, 1'b0, 32'h10, 32'h0, 4, 5);
        n_cmp++;
        if (obs_valid[3] !== 1'b1) begin n_fail++; $display("FAIL err_recheck_valid got %b want 1", obs_valid[3]); end
        n_cmp++;
        if (obs_rdata[3] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL err_recheck_rdata got %h want %h", obs_rdata[3], 32'hDEADBEEF); end
    endtask

    task automatic test_read_write_both();
        bit exp_s [5];
        exp_s = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        run_access(1'b1, 1'b1, 32'h20, 32'h1234, 4, 5);
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (obs_stall[c] !== exp_s[c]) begin n_fail++; $display("FAIL both_stall cyc%0d got %b want %b", c, obs_stall[c], exp_s[c]); end
            n_cmp++;
            if (obs_valid[c] !== 1'b0) begin n_fail++; $display("FAIL both_valid cyc%0d got %b want 0", c, obs_valid[c]); end
        end
        run_access(1'b1, 1'b0, 32'h20, 32'h0, 4, 5);
        n_cmp++;
        if (obs_valid[3] !== 1'b1) begin n_fail++; $display("FAIL both_lw_valid got %b want 1", obs_valid[3]); end
        n_cmp++;
        if (obs_rdata[3] !== 32'h1234) begin n_fail++; $display("FAIL both_lw_rdata got %h want %h", obs_rdata[3], 32'h1234); end
    endtask

    task automatic test_reset_mid_access();
        // Known prior content for word 12.
        run_access(1'b0, 1'b1, 32'h30, 32'h77, 4, 5);
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b1; addr = 32'h30; wdata = 32'h55;
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_mid_accept_stall got %b want 1", stall); end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall got %b want 0", stall); end
        n_cmp++;
        if (rdata_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", rdata_valid); end
        n_cmp++;
        if (addr_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err got %b want 0", addr_err); end
        n_cmp++;
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rdata got %h want %h", rdata, 32'h0); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_write = 1'b0; addr = '0; wdata = '0;
        rst_n = 1'b1;
        run_access(1'b1, 1'b0, 32'h30, 32'h0, 4, 5);
        n_cmp++;
        if (obs_valid[3] !== 1'b1) begin n_fail++; $display("FAIL rst_mid_lw_valid got %b want 1", obs_valid[3]); end
        n_cmp++;
        if (obs_rdata[3] !== 32'h77) begin n_fail++; $display("FAIL rst_mid_mem12 got %h want %h", obs_rdata[3], 32'h77); end
    endtask

    task automatic test_back_to_back();
        bit exp_s [8];
        bit exp_v [8];
        exp_s = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            addr = 32'h40;
            if (c < 4) begin
                mem_read = 1'b0; mem_write = 1'b1; wdata = 32'hA5A5A5A5;
            end else begin
                mem_read = 1'b1; mem_write = 1'b0; wdata = 32'h0;
            end
            @(negedge clk);
            obs_stall[c] = stall;
            obs_valid[c] = rdata_valid;
            obs_rdata[c] = rdata;
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0; addr = '0;
        for (int c = 0; c < 8; c++) begin
            n_cmp++;
            if (obs_stall[c] !== exp_s[c]) begin n_fail++; $display("FAIL b2b_stall cyc%0d got %b want %b", c, obs_stall[c], exp_s[c]); end
            n_cmp++;
            if (obs_valid[c] !== exp_v[c]) begin n_fail++; $display("FAIL b2b_valid cyc%0d got %b want %b", c, obs_valid[c], exp_v[c]); end
        end
        n_cmp++;
        if (obs_rdata[7] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL b2b_rdata got %h want %h", obs_rdata[7], 32'hA5A5A5A5); end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_addr_err();
        test_read_write_both();
        test_reset_mid_access();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
